// File: rtl/mem_arbiter_if.sv
// Memory-side bus of the arbiter: byte-lane masked 16-bit request/response.
`timescale 1ns/1ps
interface mem_arbiter_if;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  modport master (
    output mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
    input  mem_resp, mem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one 16-bit memory port between the CPU and buffered UART download writes,
// and paces the CPU with a one-cycle clock enable after each bus cycle or step.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter logic [15:0] UART_BASE  = 16'h0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic [7:0]    uart_data,
  input  logic [7:0]    uart_addr,
  input  logic          uart_write,
  input  logic          uart_checksum_error,
  input  logic          hold_cpu,
  input  logic [15:0]   cpu_aout,
  input  logic [7:0]    cpu_dout,
  input  logic          cpu_mr,
  input  logic          cpu_mw,
  output logic          cpu_ce,
  output logic [7:0]    cpu_din,
  mem_arbiter_if.master mem,
  output logic          uart_overflow,
  output logic          busy
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] UART_ACC = 2'd1;
  localparam logic [1:0] CPU_ACC  = 2'd2;
  localparam logic [1:0] STEP     = 2'd3;

  logic [1:0]  r_state, w_state_nxt;
  logic [23:0] r_fifo [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt, w_count, w_count_nxt;
  logic [23:0] w_head, w_entry;
  logic        w_empty, w_full, w_flush, w_push_req, w_push, w_pop, w_drop, w_cpu_req;

  logic        r_cpu_rd, r_lane, r_cpu_ce, r_ovf, r_busy;
  logic [7:0]  r_cpu_din;
  logic        r_mem_read, r_mem_write;
  logic [1:0]  r_wmask;
  logic [15:0] r_addr, r_wdata;

  // Pointers carry one extra bit so full/empty are distinguishable; full is count == DEPTH.
  assign w_count    = r_wptr - r_rptr;
  assign w_empty    = (w_count == '0);
  assign w_full     = w_count[AW];
  assign w_flush    = uart_checksum_error;
  assign w_pop      = (r_state == IDLE) && !w_empty && !w_flush;
  assign w_push_req = uart_write && !w_flush;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_entry    = {UART_BASE + {8'h00, uart_addr}, uart_data};
  assign w_head     = r_fifo[r_rptr[AW-1:0]];
  assign w_cpu_req  = !hold_cpu && (cpu_mr || cpu_mw);

  always_comb begin
    w_wptr_nxt  = r_wptr + {{AW{1'b0}}, w_push};
    w_rptr_nxt  = w_flush ? r_wptr : r_rptr + {{AW{1'b0}}, w_pop};
    w_count_nxt = w_wptr_nxt - w_rptr_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_pop)          w_state_nxt = UART_ACC;
        else if (w_cpu_req) w_state_nxt = CPU_ACC;
        else if (!hold_cpu) w_state_nxt = STEP;
      end
      UART_ACC: if (mem.mem_resp) w_state_nxt = IDLE;
      CPU_ACC:  if (mem.mem_resp) w_state_nxt = STEP;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr[AW-1:0]] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cpu_rd    <= 1'b0;
      r_lane      <= 1'b0;
      r_cpu_ce    <= 1'b0;
      r_cpu_din   <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_wmask     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_ovf       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      r_cpu_ce <= (w_state_nxt == STEP);
      r_busy   <= (w_state_nxt != IDLE) || (w_count_nxt != '0);
      if (w_drop) r_ovf <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_mem_write <= 1'b1;
            r_addr      <= {w_head[23:9], 1'b0};
            r_wmask     <= w_head[8] ? 2'b10 : 2'b01;
            r_wdata     <= {w_head[7:0], w_head[7:0]};
          end else if (w_cpu_req) begin
            // Simultaneous read and write requests resolve to a write.
            r_cpu_rd    <= !cpu_mw;
            r_lane      <= cpu_aout[0];
            r_addr      <= {cpu_aout[15:1], 1'b0};
            r_mem_write <= cpu_mw;
            r_mem_read  <= !cpu_mw;
            r_wmask     <= cpu_mw ? (cpu_aout[0] ? 2'b10 : 2'b01) : 2'b00;
            r_wdata     <= cpu_mw ? {cpu_dout, cpu_dout} : 16'h0000;
          end
        end
        UART_ACC, CPU_ACC: begin
          if (mem.mem_resp) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_state == CPU_ACC && r_cpu_rd)
              r_cpu_din <= r_lane ? mem.mem_rdata[15:8] : mem.mem_rdata[7:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_ce          = r_cpu_ce;
  assign cpu_din         = r_cpu_din;
  assign uart_overflow   = r_ovf;
  assign busy            = r_busy;
  assign mem.mem_read    = r_mem_read;
  assign mem.mem_write   = r_mem_write;
  assign mem.mem_wmask   = r_wmask;
  assign mem.mem_address = r_addr;
  assign mem.mem_wdata   = r_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory accesses and CPU steps are queued
// by the stimulus and consumed by a monitor whenever the DUT presents them.
`timescale 1ns/1ps
module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        RESET;
  logic [7:0]  uart_data, uart_addr;
  logic        uart_write, uart_checksum_error, hold_cpu;
  logic [15:0] cpu_aout;
  logic [7:0]  cpu_dout;
  logic        cpu_mr, cpu_mw;
  logic        cpu_ce;
  logic [7:0]  cpu_din;
  logic        uart_overflow, busy;

  mem_arbiter_if mif();

  mem_arbiter #(.UART_BASE(16'h8000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .RESET(RESET),
    .uart_data(uart_data), .uart_addr(uart_addr), .uart_write(uart_write),
    .uart_checksum_error(uart_checksum_error), .hold_cpu(hold_cpu),
    .cpu_aout(cpu_aout), .cpu_dout(cpu_dout), .cpu_mr(cpu_mr), .cpu_mw(cpu_mw),
    .cpu_ce(cpu_ce), .cpu_din(cpu_din), .mem(mif.master),
    .uart_overflow(uart_overflow), .busy(busy)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  mask;
    logic [15:0] wdata;
  } mtx_t;
  typedef struct {
    logic       chk;
    logic [7:0] din;
  } ce_t;

  mtx_t exp_mem[$];
  ce_t  exp_ce[$];
  int   checks = 0, errors = 0;
  int   rd_cycles = 0, wr_cycles = 0, ce_cnt = 0;
  logic mem_en = 1'b1;
  int   wait_n = 0;
  int   mcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: answers after wait_n extra cycles, unless mem_en is low.
  always @(negedge clk) begin
    if (RESET || !(mif.mem_read || mif.mem_write)) begin
      mif.mem_resp = 1'b0;
      mcnt = 0;
    end else if (!mif.mem_resp && mem_en) begin
      if (mcnt >= wait_n) mif.mem_resp = 1'b1;
      else mcnt++;
    end
  end

  // Monitor: consumes expected accesses at strobe rise and expected steps at cpu_ce.
  logic prev_str = 1'b0;
  mtx_t cur;
  always @(negedge clk) begin : mon
    logic str;
    mtx_t e;
    ce_t  c;
    str = mif.mem_read || mif.mem_write;
    if (mif.mem_read)  rd_cycles++;
    if (mif.mem_write) wr_cycles++;
    if (str && !prev_str) begin
      if (exp_mem.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_mem_access: addr %h rd %b wr %b, none expected",
                 mif.mem_address, mif.mem_read, mif.mem_write);
      end else begin
        e = exp_mem.pop_front();
        cur = e;
        chk("mem_write", {31'd0, mif.mem_write}, {31'd0, e.wr});
        chk("mem_read", {31'd0, mif.mem_read}, {31'd0, !e.wr});
        chk("mem_address", {16'd0, mif.mem_address}, {16'd0, e.addr});
        chk("mem_wmask", {30'd0, mif.mem_wmask}, {30'd0, e.mask});
        if (e.wr) chk("mem_wdata", {16'd0, mif.mem_wdata}, {16'd0, e.wdata});
      end
    end else if (str) begin
      chk("mem_address_stable", {16'd0, mif.mem_address}, {16'd0, cur.addr});
      chk("mem_wmask_stable", {30'd0, mif.mem_wmask}, {30'd0, cur.mask});
      if (cur.wr) chk("mem_wdata_stable", {16'd0, mif.mem_wdata}, {16'd0, cur.wdata});
    end
    prev_str = str;
    if (cpu_ce) begin
      ce_cnt++;
      if (exp_ce.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_cpu_ce: cpu_din %h, none expected", cpu_din);
      end else begin
        c = exp_ce.pop_front();
        chk("ce_after_mem_done", exp_mem.size(), 0);
        chk("ce_strobes_low", {31'd0, str}, 32'd0);
        if (c.chk) chk("cpu_din", {24'd0, cpu_din}, {24'd0, c.din});
      end
    end
  end

  // One CPU bus cycle; returns negedges from request to cpu_ce (cycle-2 timing gives 2).
  task automatic cpu_access(input logic wr, input logic [15:0] a, input logic [7:0] d,
                            input logic [15:0] rdat, input int waits, output int lat);
    logic [7:0] lane;
    lane = a[0] ? rdat[15:8] : rdat[7:0];
    wait_n = waits;
    mif.mem_rdata = rdat;
    exp_mem.push_back(mtx_t'{wr, {a[15:1], 1'b0}, wr ? (a[0] ? 2'b10 : 2'b01) : 2'b00, {d, d}});
    exp_ce.push_back(ce_t'{!wr, lane});
    cpu_aout = a; cpu_dout = d; cpu_mw = wr; cpu_mr = !wr; hold_cpu = 1'b0;
    lat = 0;
    while (!cpu_ce && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!cpu_ce) begin
      checks++; errors++;
      $display("FAIL cpu_ce_timeout: no cpu_ce within %0d cycles", lat);
    end
    hold_cpu = 1'b1; cpu_mr = 1'b0; cpu_mw = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, r0, w0, c0;
    RESET = 1'b1; uart_data = '0; uart_addr = '0; uart_write = 1'b0;
    uart_checksum_error = 1'b0; hold_cpu = 1'b1; cpu_aout = '0; cpu_dout = '0;
    cpu_mr = 1'b0; cpu_mw = 1'b0; mif.mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_ce", {31'd0, cpu_ce}, 0);
    chk("rst_strobes", {30'd0, mif.mem_read, mif.mem_write}, 0);
    chk("rst_overflow_busy", {30'd0, uart_overflow, busy}, 0);
    chk("rst_bus", {mif.mem_address, mif.mem_wdata}, 0);
    chk("rst_mask_din", {22'd0, mif.mem_wmask, cpu_din}, 0);
    RESET = 1'b0;
    @(negedge clk);

    // CPU read, zero wait, odd byte
    r0 = rd_cycles;
    cpu_access(1'b0, 16'h1235, 8'h00, 16'hBEEF, 0, lat);
    chk("read_latency", lat, 2);
    chk("read_strobe_cycles", rd_cycles - r0, 1);
    @(negedge clk);
    chk("read_din_hold", {24'd0, cpu_din}, 32'h0000_00BE);

    // CPU write, three wait cycles
    w0 = wr_cycles;
    cpu_access(1'b1, 16'h0040, 8'h5A, 16'h0000, 3, lat);
    chk("write_latency", lat, 5);
    chk("write_strobe_cycles", wr_cycles - w0, 4);
    @(negedge clk);
    chk("write_keeps_din", {24'd0, cpu_din}, 32'h0000_00BE);

    // Non-memory step: IDLE -> STEP
    c0 = ce_cnt;
    exp_ce.push_back(ce_t'{1'b0, 8'h00});
    hold_cpu = 1'b0;
    @(negedge clk);
    hold_cpu = 1'b1;
    chk("step_ce", {31'd0, cpu_ce}, 1);
    repeat (4) @(negedge clk);
    chk("step_count", ce_cnt - c0, 1);

    // UART priority over a pending CPU read
    wait_n = 0;
    exp_mem.push_back(mtx_t'{1'b1, 16'h8002, 2'b10, 16'h1111});
    uart_addr = 8'h03; uart_data = 8'h11; uart_write = 1'b1;
    @(negedge clk);
    uart_write = 1'b0;
    chk("uart_busy", {31'd0, busy}, 1);
    cpu_access(1'b0, 16'h0011, 8'h00, 16'hCAFE, 0, lat);
    chk("uart_then_cpu_latency", lat, 4);
    @(negedge clk);

    // Overflow then flush while the first write is stalled
    mem_en = 1'b0;
    exp_mem.push_back(mtx_t'{1'b1, 16'h8020, 2'b01, 16'hA0A0});
    for (int i = 0; i < 6; i++) begin
      uart_addr = 8'h20 + 8'(i); uart_data = 8'hA0 + 8'(i); uart_write = 1'b1;
      @(negedge clk);
      if (i == 4) chk("no_overflow_at_full", {31'd0, uart_overflow}, 0);
    end
    uart_write = 1'b0;
    chk("overflow_set", {31'd0, uart_overflow}, 1);
    chk("overflow_busy", {31'd0, busy}, 1);
    chk("inflight_write", {31'd0, mif.mem_write}, 1);
    uart_checksum_error = 1'b1; uart_write = 1'b1; uart_addr = 8'h30;
    @(negedge clk);
    uart_checksum_error = 1'b0; uart_write = 1'b0;
    chk("flush_inflight_held", {31'd0, mif.mem_write}, 1);
    mem_en = 1'b1;
    repeat (6) @(negedge clk);
    chk("flush_write_done", {31'd0, mif.mem_write}, 0);
    chk("flush_idle_busy", {31'd0, busy}, 0);
    chk("overflow_sticky", {31'd0, uart_overflow}, 1);
    chk("flush_no_more_writes", exp_mem.size(), 0);

    // Reset in the middle of a CPU access
    mem_en = 1'b0;
    exp_mem.push_back(mtx_t'{1'b0, 16'h0100, 2'b00, 16'h0000});
    cpu_aout = 16'h0100; cpu_mr = 1'b1; hold_cpu = 1'b0;
    @(negedge clk);
    chk("pre_reset_read", {31'd0, mif.mem_read}, 1);
    cpu_mr = 1'b0; hold_cpu = 1'b1; RESET = 1'b1;
    @(negedge clk);
    chk("midrst_strobe", {31'd0, mif.mem_read}, 0);
    chk("midrst_flags", {29'd0, cpu_ce, busy, uart_overflow}, 0);
    chk("midrst_bus", {14'd0, mif.mem_wmask, mif.mem_address}, 0);
    chk("midrst_din", {24'd0, cpu_din}, 0);
    @(negedge clk);
    RESET = 1'b0; mem_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", {30'd0, busy, mif.mem_read}, 0);

    // Hold blocks a pending read; release starts it promptly
    cpu_aout = 16'h2001; cpu_mr = 1'b1; mif.mem_rdata = 16'h7788;
    r0 = rd_cycles; c0 = ce_cnt;
    repeat (20) @(negedge clk);
    chk("hold_no_read", rd_cycles - r0, 0);
    chk("hold_no_ce", ce_cnt - c0, 0);
    cpu_access(1'b0, 16'h2001, 8'h00, 16'h7788, 1, lat);
    chk("hold_release_latency", lat, 3);
    repeat (3) @(negedge clk);

    chk("mem_queue_drained", exp_mem.size(), 0);
    chk("ce_queue_drained", exp_ce.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
